// File: rtl/pool_sched_pkg.sv
// Shared types and default widths for the pooling scheduler.
package pool_sched_pkg;

   localparam int ADDR_WIDTH_DEF    = 12;
   localparam int HEIGHT_WIDTH_DEF  = 7;
   localparam int KERSIZE_WIDTH_DEF = 5;
   localparam int CH_WIDTH_DEF      = 6;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      NEXT = 3'd3,
      FIN  = 3'd4
   } state_e;

endpackage

// File: rtl/pool_sched_desc_chk.sv
// Combinational validity check of a pooling job descriptor:
// all dimensions non-zero and the kernel fits inside the map.
module pool_desc_chk
   import pool_sched_pkg::*;
#(
   parameter int HEIGHT_WIDTH  = HEIGHT_WIDTH_DEF,
   parameter int KERSIZE_WIDTH = KERSIZE_WIDTH_DEF,
   parameter int CH_WIDTH      = CH_WIDTH_DEF
) (
   input  logic [HEIGHT_WIDTH-1:0]  h,
   input  logic [HEIGHT_WIDTH-1:0]  w,
   input  logic [KERSIZE_WIDTH-1:0] k,
   input  logic [KERSIZE_WIDTH-1:0] l,
   input  logic [CH_WIDTH-1:0]      c,
   output logic                     ok
);

   localparam int DW = (HEIGHT_WIDTH > KERSIZE_WIDTH) ? HEIGHT_WIDTH : KERSIZE_WIDTH;

   logic [DW-1:0] h_x, w_x, k_x, l_x;

   always_comb begin
      h_x = DW'(h);
      w_x = DW'(w);
      k_x = DW'(k);
      l_x = DW'(l);
      ok  = (h_x != '0) && (w_x != '0) && (k_x != '0) && (l_x != '0) &&
            (c != '0) && (k_x <= h_x) && (l_x <= w_x);
   end

endmodule

// File: rtl/pool_sched.sv
// Pooling job scheduler: sequences an external address generator once per
// channel and rebases its relative addresses. PERF_STALL exists only when
// POOL_SCHED_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a descriptor, CFG_READY high
// LOAD  | one-cycle AG_START to the generator
// RUN   | streaming generator beats to OUT_*
// NEXT  | advance channel base / index, generator idles
// FIN   | one-cycle DONE pulse
module pool_sched
   import pool_sched_pkg::*;
#(
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int HEIGHT_WIDTH  = HEIGHT_WIDTH_DEF,
   parameter int KERSIZE_WIDTH = KERSIZE_WIDTH_DEF,
   parameter int CH_WIDTH      = CH_WIDTH_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     CFG_VALID,
   output logic                     CFG_READY,
   input  logic [HEIGHT_WIDTH-1:0]  CFG_H,
   input  logic [HEIGHT_WIDTH-1:0]  CFG_W,
   input  logic [KERSIZE_WIDTH-1:0] CFG_K,
   input  logic [KERSIZE_WIDTH-1:0] CFG_L,
   input  logic [CH_WIDTH-1:0]      CFG_C,
   input  logic [ADDR_WIDTH-1:0]    CFG_BASE,
   output logic                     AG_EN,
   output logic                     AG_START,
   output logic [HEIGHT_WIDTH-1:0]  AG_H,
   output logic [HEIGHT_WIDTH-1:0]  AG_W,
   output logic [KERSIZE_WIDTH-1:0] AG_K,
   output logic [KERSIZE_WIDTH-1:0] AG_L,
   input  logic                     AG_BIAS_VALID,
   input  logic                     AG_BIAS_PACK,
   input  logic                     AG_BIAS_LAST,
   input  logic [ADDR_WIDTH-1:0]    AG_BIAS,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [ADDR_WIDTH-1:0]    OUT_ADDR,
   output logic                     OUT_PACK,
   output logic [CH_WIDTH-1:0]      OUT_CH,
`ifdef POOL_SCHED_PERF_EN
   output logic [31:0]              PERF_STALL,
`endif
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     ERR
);

   state_e                   state_q, state_d;
   logic                     live_q;
   logic                     err_q, err_d;
   logic [HEIGHT_WIDTH-1:0]  h_q, h_d, w_q, w_d;
   logic [KERSIZE_WIDTH-1:0] k_q, k_d, l_q, l_d;
   logic [CH_WIDTH-1:0]      c_q, c_d, ch_q, ch_d;
   logic [ADDR_WIDTH-1:0]    chan_base_q, chan_base_d;
   logic [2*HEIGHT_WIDTH-1:0] area;
   logic                     desc_ok;
   logic                     accept;

   pool_desc_chk #(
      .HEIGHT_WIDTH  (HEIGHT_WIDTH),
      .KERSIZE_WIDTH (KERSIZE_WIDTH),
      .CH_WIDTH      (CH_WIDTH)
   ) u_desc_chk (
      .h  (CFG_H),
      .w  (CFG_W),
      .k  (CFG_K),
      .l  (CFG_L),
      .c  (CFG_C),
      .ok (desc_ok)
   );

   // live_q keeps the handshake outputs low until the first edge after reset
   assign accept = (state_q == IDLE) && live_q && CFG_VALID;
   assign area   = {{HEIGHT_WIDTH{1'b0}}, h_q} * {{HEIGHT_WIDTH{1'b0}}, w_q};

   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      h_d         = h_q;
      w_d         = w_q;
      k_d         = k_q;
      l_d         = l_q;
      c_d         = c_q;
      ch_d        = ch_q;
      chan_base_d = chan_base_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               h_d         = CFG_H;
               w_d         = CFG_W;
               k_d         = CFG_K;
               l_d         = CFG_L;
               c_d         = CFG_C;
               chan_base_d = CFG_BASE;
               ch_d        = '0;
               if (desc_ok) state_d = LOAD;
               else         err_d   = 1'b1;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (AG_BIAS_VALID && OUT_READY && AG_BIAS_LAST) state_d = NEXT;
         end
         NEXT: begin
            chan_base_d = chan_base_q + ADDR_WIDTH'(area);
            if (ch_q == c_q - CH_WIDTH'(1)) begin
               state_d = FIN;
            end else begin
               ch_d    = ch_q + CH_WIDTH'(1);
               state_d = LOAD;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         live_q      <= 1'b0;
         err_q       <= 1'b0;
         h_q         <= '0;
         w_q         <= '0;
         k_q         <= '0;
         l_q         <= '0;
         c_q         <= '0;
         ch_q        <= '0;
         chan_base_q <= '0;
      end else begin
         state_q     <= state_d;
         live_q      <= 1'b1;
         err_q       <= err_d;
         h_q         <= h_d;
         w_q         <= w_d;
         k_q         <= k_d;
         l_q         <= l_d;
         c_q         <= c_d;
         ch_q        <= ch_d;
         chan_base_q <= chan_base_d;
      end
   end

   assign CFG_READY = live_q && (state_q == IDLE);
   assign AG_START  = (state_q == LOAD);
   assign AG_EN     = (state_q == RUN) ? (OUT_READY || !AG_BIAS_VALID) : live_q;
   assign AG_H      = h_q;
   assign AG_W      = w_q;
   assign AG_K      = k_q;
   assign AG_L      = l_q;
   assign OUT_VALID = (state_q == RUN) && AG_BIAS_VALID;
   assign OUT_ADDR  = live_q ? (chan_base_q + AG_BIAS) : '0;
   assign OUT_PACK  = AG_BIAS_PACK;
   assign OUT_CH    = ch_q;
   assign BUSY      = (state_q != IDLE);
   assign DONE      = (state_q == FIN);
   assign ERR       = err_q;

`ifdef POOL_SCHED_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (accept) begin
         stall_d = '0;
      end else if ((state_q == RUN) && AG_BIAS_VALID && !OUT_READY && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) stall_q <= '0;
      else          stall_q <= stall_d;
   end

   assign PERF_STALL = stall_q;
`endif

endmodule

// File: tb/tb_pool_sched.sv
// Directed bench for pool_sched with a behavioural window-order address generator.
module tb_pool_sched;

   logic        clk, rst_n;
   logic        cfg_valid, cfg_ready;
   logic [6:0]  cfg_h, cfg_w;
   logic [4:0]  cfg_k, cfg_l;
   logic [5:0]  cfg_c;
   logic [11:0] cfg_base;
   logic        ag_en, ag_start;
   logic [6:0]  ag_h, ag_w;
   logic [4:0]  ag_k, ag_l;
   logic        g_valid, g_pack, g_last;
   logic [11:0] g_bias;
   logic        out_valid, out_ready, out_pack;
   logic [11:0] out_addr;
   logic [5:0]  out_ch;
   logic        busy, done, err;
`ifdef POOL_SCHED_PERF_EN
   logic [31:0] perf_stall;
`endif

   pool_sched dut (
      .CLK(clk), .RESET_N(rst_n),
      .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
      .CFG_H(cfg_h), .CFG_W(cfg_w), .CFG_K(cfg_k), .CFG_L(cfg_l),
      .CFG_C(cfg_c), .CFG_BASE(cfg_base),
      .AG_EN(ag_en), .AG_START(ag_start),
      .AG_H(ag_h), .AG_W(ag_w), .AG_K(ag_k), .AG_L(ag_l),
      .AG_BIAS_VALID(g_valid), .AG_BIAS_PACK(g_pack), .AG_BIAS_LAST(g_last),
      .AG_BIAS(g_bias),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_ADDR(out_addr),
      .OUT_PACK(out_pack), .OUT_CH(out_ch),
`ifdef POOL_SCHED_PERF_EN
      .PERF_STALL(perf_stall),
`endif
      .BUSY(busy), .DONE(done), .ERR(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural address generator ----------------
   int g_oy, g_ox, g_ky, g_kx;
   int g_nr, g_nc;

   always_comb begin
      g_nr   = (ag_k == 0) ? 1 : int'(ag_h) / int'(ag_k);
      g_nc   = (ag_l == 0) ? 1 : int'(ag_w) / int'(ag_l);
      g_bias = 12'((g_oy * int'(ag_k) + g_ky) * int'(ag_w) + g_ox * int'(ag_l) + g_kx);
      g_pack = (g_ky == int'(ag_k) - 1) && (g_kx == int'(ag_l) - 1);
      g_last = g_pack && (g_oy == g_nr - 1) && (g_ox == g_nc - 1);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_valid <= 1'b0;
         g_oy <= 0; g_ox <= 0; g_ky <= 0; g_kx <= 0;
      end else if (ag_en) begin
         if (ag_start) begin
            g_valid <= 1'b1;
            g_oy <= 0; g_ox <= 0; g_ky <= 0; g_kx <= 0;
         end else if (g_valid) begin
            if (g_last) g_valid <= 1'b0;
            else if (g_kx < int'(ag_l) - 1) g_kx <= g_kx + 1;
            else begin
               g_kx <= 0;
               if (g_ky < int'(ag_k) - 1) g_ky <= g_ky + 1;
               else begin
                  g_ky <= 0;
                  if (g_ox < g_nc - 1) g_ox <= g_ox + 1;
                  else begin
                     g_ox <= 0;
                     g_oy <= g_oy + 1;
                  end
               end
            end
         end
      end
   end

   // ---------------- checking infrastructure ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   logic [11:0] q_addr[$];
   bit          q_pack[$];
   int          q_ch[$];
   int          n_done, n_err, n_start;
   int          rdy_mode;     // 0: always ready, 1: random, 2: rdy_manual
   logic        rdy_manual;
   bit          prev_stall = 1'b0;
   logic [11:0] prev_addr;
   logic        prev_pack;
   logic [5:0]  prev_ch;

   always begin
      @(negedge clk);
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else                    out_ready = rdy_manual;
      #1;
      if (out_valid && out_ready) begin
         q_addr.push_back(out_addr);
         q_pack.push_back(out_pack);
         q_ch.push_back(int'(out_ch));
      end
      if (prev_stall && out_valid)
         chk("stall_hold", int'({out_addr, out_pack, out_ch}), int'({prev_addr, prev_pack, prev_ch}));
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_pack  = out_pack;
      prev_ch    = out_ch;
      if (done)     n_done++;
      if (err)      n_err++;
      if (ag_start) n_start++;
   end

   task automatic clear_log();
      q_addr.delete();
      q_pack.delete();
      q_ch.delete();
      n_done = 0; n_err = 0; n_start = 0;
   endtask

   task automatic submit(input int h, w, k, l, c, base);
      @(negedge clk);
      cfg_h = 7'(h); cfg_w = 7'(w); cfg_k = 5'(k); cfg_l = 5'(l);
      cfg_c = 6'(c); cfg_base = 12'(base);
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic run_job(input int h, w, k, l, c, base, input bit poke,
                          output bit timed_out, output logic err_now, output logic busy_now);
      int cyc;
      clear_log();
      submit(h, w, k, l, c, base);
      err_now  = err;
      busy_now = busy;
      if (poke) begin
         cfg_c = 6'd0; cfg_k = 5'd0; cfg_base = 12'd999;
         cfg_valid = 1'b1;
         repeat (6) @(negedge clk);
         cfg_valid = 1'b0;
      end
      cyc = 0;
      while ((busy || cyc < 3) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      timed_out = (cyc >= 3000);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [7:0][11:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [7:0][11:0] r;
      r[0] = 12'(a0); r[1] = 12'(a1); r[2] = 12'(a2); r[3] = 12'(a3);
      r[4] = 12'(a4); r[5] = 12'(a5); r[6] = 12'(a6); r[7] = 12'(a7);
      return r;
   endfunction

   typedef struct {
      int               h, w, k, l, c, base, mode;
      bit               poke;
      int               beats;
      logic [7:0][11:0] a8;
      logic [7:0]       pmask;
      logic [3:0][11:0] c1;
      int               packs, dones, errs, starts;
   } vec_t;

   vec_t        vecs[7];
   logic [11:0] ref_seq[$];

   initial begin
      bit          to;
      logic        e_now, b_now;
      int          cyc, nb, mism;

      rst_n = 1'b0; cfg_valid = 1'b0;
      cfg_h = '0; cfg_w = '0; cfg_k = '0; cfg_l = '0; cfg_c = '0; cfg_base = '0;
      rdy_mode = 0; rdy_manual = 1'b1; out_ready = 1'b1;

      vecs[0] = '{h:4, w:4, k:2, l:2, c:1, base:0, mode:0, poke:0, beats:16,
                  a8:pk8(0,1,4,5,2,3,6,7), pmask:8'h88, c1:'0,
                  packs:4, dones:1, errs:0, starts:1};
      vecs[1] = '{h:4, w:4, k:2, l:2, c:2, base:100, mode:0, poke:1, beats:32,
                  a8:pk8(100,101,104,105,102,103,106,107), pmask:8'h88,
                  c1:{12'd121, 12'd120, 12'd117, 12'd116},
                  packs:8, dones:1, errs:0, starts:2};
      vecs[2] = vecs[0];
      vecs[2].mode = 1;
      vecs[3] = '{h:4, w:4, k:0, l:2, c:1, base:0, mode:0, poke:0, beats:0,
                  a8:'0, pmask:8'h00, c1:'0, packs:0, dones:0, errs:1, starts:0};
      vecs[4] = '{h:2, w:4, k:3, l:2, c:1, base:0, mode:0, poke:0, beats:0,
                  a8:'0, pmask:8'h00, c1:'0, packs:0, dones:0, errs:1, starts:0};
      vecs[5] = '{h:3, w:2, k:3, l:1, c:1, base:4090, mode:0, poke:0, beats:6,
                  a8:pk8(4090,4092,4094,4091,4093,4095,0,0), pmask:8'h24, c1:'0,
                  packs:2, dones:1, errs:0, starts:1};
      vecs[6] = '{h:4, w:4, k:2, l:2, c:0, base:0, mode:0, poke:0, beats:0,
                  a8:'0, pmask:8'h00, c1:'0, packs:0, dones:0, errs:1, starts:0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_ready", int'(cfg_ready), 0);
      chk("rst_ag_en",     int'(ag_en), 0);
      chk("rst_ag_start",  int'(ag_start), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_done_err",  int'({done, err}), 0);
      chk("rst_out_addr",  int'(out_addr), 0);
      chk("rst_out_ch",    int'(out_ch), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_edge_cfg_ready", int'(cfg_ready), 1);
      chk("first_edge_ag_en",     int'(ag_en), 1);

      for (int i = 0; i < 7; i++) begin
         rdy_mode = vecs[i].mode;
         run_job(vecs[i].h, vecs[i].w, vecs[i].k, vecs[i].l, vecs[i].c, vecs[i].base,
                 vecs[i].poke, to, e_now, b_now);
         rdy_mode = 0;
         chk($sformatf("v%0d_timeout", i), int'(to), 0);
         chk($sformatf("v%0d_err_now", i), int'(e_now), vecs[i].errs);
         chk($sformatf("v%0d_busy_now", i), int'(b_now), (vecs[i].errs == 0) ? 1 : 0);
         chk($sformatf("v%0d_beats", i), q_addr.size(), vecs[i].beats);
         nb = (q_addr.size() < 8) ? q_addr.size() : 8;
         for (int j = 0; j < nb; j++) begin
            chk($sformatf("v%0d_addr%0d", i, j), int'(q_addr[j]), int'(vecs[i].a8[j]));
            chk($sformatf("v%0d_pack%0d", i, j), int'(q_pack[j]), int'(vecs[i].pmask[j]));
         end
         if (vecs[i].beats > 0 && q_ch.size() > 0)
            chk($sformatf("v%0d_ch0", i), q_ch[0], 0);
         if (vecs[i].beats > 16 && q_addr.size() >= 20) begin
            for (int j = 0; j < 4; j++) begin
               chk($sformatf("v%0d_c1_addr%0d", i, j), int'(q_addr[16+j]), int'(vecs[i].c1[j]));
               chk($sformatf("v%0d_c1_ch%0d", i, j), q_ch[16+j], 1);
            end
         end
         mism = 0;
         foreach (q_pack[j]) if (q_pack[j]) mism++;
         chk($sformatf("v%0d_packs", i), mism, vecs[i].packs);
         chk($sformatf("v%0d_done", i), n_done, vecs[i].dones);
         chk($sformatf("v%0d_err", i), n_err, vecs[i].errs);
         chk($sformatf("v%0d_starts", i), n_start, vecs[i].starts);
         chk($sformatf("v%0d_idle", i), int'(busy), 0);
         if (i == 0) ref_seq = q_addr;
         if (i == 2) begin
            mism = 0;
            if (q_addr.size() != ref_seq.size()) mism = 1;
            else foreach (q_addr[j]) if (q_addr[j] != ref_seq[j]) mism++;
            chk("rand_ready_seq", mism, 0);
         end
      end

      // reset in the middle of channel 1 of a 3-channel job
      clear_log();
      rdy_mode = 0;
      submit(4, 4, 2, 2, 3, 0);
      cyc = 0;
      while (!(out_ch == 6'd1 && q_addr.size() >= 20) && cyc < 500) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      chk("mid_reset_reach_ch1", int'(cyc < 500), 1);
      rst_n = 1'b0;
      #2;
      chk("mrst_cfg_ready", int'(cfg_ready), 0);
      chk("mrst_ag_en_start", int'({ag_en, ag_start}), 0);
      chk("mrst_out_valid", int'(out_valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done_err", int'({done, err}), 0);
      chk("mrst_out_addr", int'(out_addr), 0);
      chk("mrst_out_ch", int'(out_ch), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nb = q_addr.size();
      repeat (6) @(negedge clk);
      #2;
      chk("mrst_no_beats_after", q_addr.size() - nb, 0);
      chk("mrst_no_done", n_done, 0);
      chk("mrst_ready_again", int'(cfg_ready), 1);
      run_job(4, 4, 2, 2, 1, 8, 1'b0, to, e_now, b_now);
      chk("post_rst_timeout", int'(to), 0);
      chk("post_rst_beats", q_addr.size(), 16);
      if (q_addr.size() > 0) chk("post_rst_addr0", int'(q_addr[0]), 8);
      chk("post_rst_done", n_done, 1);

`ifdef POOL_SCHED_PERF_EN
      clear_log();
      rdy_mode = 2;
      rdy_manual = 1'b1;
      submit(4, 4, 2, 2, 1, 0);
      cyc = 0;
      while (q_addr.size() < 4 && cyc < 200) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      rdy_manual = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rdy_manual = 1'b1;
      cyc = 0;
      while (!done && cyc < 500) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      chk("perf_done_seen", int'(done), 1);
      chk("perf_stall", int'(perf_stall), 5);
      repeat (3) @(negedge clk);
      chk("perf_beats", q_addr.size(), 16);
      rdy_mode = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
